// File: rtl/erasable_pkg.sv
// +----------------------------------------------------------------------+
// | erasable_pkg                                                         |
// | Shared constants and types for the erasable memory cycle controller: |
// | address field layout, time-pulse numbers, strobe windows, states.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package erasable_pkg;

  // Erasable address layout: [10:8] bank, [7:6] YB, [5:3] XT, [2:0] XB
  localparam int c_addr_w    = 11;
  localparam int c_eb_w      = 3;
  localparam int c_eb_lsb    = 8;
  localparam int c_yb_sel_w  = 2;
  localparam int c_yb_lsb    = 6;
  localparam int c_xt_sel_w  = 3;
  localparam int c_xt_lsb    = 3;
  localparam int c_xb_sel_w  = 3;
  localparam int c_xb_lsb    = 0;

  // Time pulses; 0 means idle
  localparam logic [3:0] c_t00 = 4'd0;
  localparam logic [3:0] c_t01 = 4'd1;
  localparam logic [3:0] c_t02 = 4'd2;
  localparam logic [3:0] c_t03 = 4'd3;
  localparam logic [3:0] c_t04 = 4'd4;
  localparam logic [3:0] c_t05 = 4'd5;
  localparam logic [3:0] c_t06 = 4'd6;
  localparam logic [3:0] c_t07 = 4'd7;
  localparam logic [3:0] c_t08 = 4'd8;
  localparam logic [3:0] c_t09 = 4'd9;
  localparam logic [3:0] c_t10 = 4'd10;
  localparam logic [3:0] c_t11 = 4'd11;
  localparam logic [3:0] c_t12 = 4'd12;

  // Read half of the cycle ends at T06; write-back occupies T07..T12
  localparam logic [3:0] c_rd_last   = c_t06;

  // Strobe windows (inclusive)
  localparam logic [3:0] c_re_first  = c_t02;
  localparam logic [3:0] c_re_last   = c_t04;
  localparam logic [3:0] c_sbe_first = c_t04;
  localparam logic [3:0] c_sbe_last  = c_t04;
  localparam logic [3:0] c_zid_first = c_t08;
  localparam logic [3:0] c_zid_last  = c_t10;
  localparam logic [3:0] c_we_first  = c_t08;
  localparam logic [3:0] c_we_last   = c_t10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  function automatic logic in_window(input logic [3:0] tp,
                                     input logic [3:0] first,
                                     input logic [3:0] last);
    return (tp >= first) && (tp <= last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_dec.sv
// +----------------------------------------------------------------------+
// | onehot_dec                                                           |
// | N -> 2^N one-hot decoder with enable; all-zero when disabled.        |
// | Ports: en (enable), sel [N-1:0] (binary index), dec [2^N-1:0]        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module onehot_dec #(
  parameter int N = 2
) (
  input  logic                en,
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   dec
);

  for (genvar i = 0; i < (1 << N); i++) begin : g_bit
    assign dec[i] = en && (sel == N'(i));
  end

endmodule

`default_nettype wire

// File: rtl/erasable_cycle_ctl.sv
// +----------------------------------------------------------------------+
// | erasable_cycle_ctl                                                   |
// | Arbiter and 12-time-pulse read/write-back sequencer for the erasable |
// | core memory. CTR requests have priority over CPU requests.          |
// | Ports: CLOCK, rst_ (async active-low), GOJAM (sync abort),           |
// |   CPU_REQ/CPU_ADDR, CTR_REQ/CTR_ADDR in; CPU_GNT, CTR_GNT, BUSY, TP, |
// |   EB, YB, XT, XB, REX, REY, SBE, ZID, WEX, WEY, CYDONE out.          |
// | Macro: ERAS_FAIR_EN enables the CPU starvation guard.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module erasable_cycle_ctl
  import erasable_pkg::*;
#(
  parameter int TP_CLKS = 2
) (
  input  logic                CLOCK,
  input  logic                rst_,
  input  logic                GOJAM,
  input  logic                CPU_REQ,
  input  logic [c_addr_w-1:0] CPU_ADDR,
  input  logic                CTR_REQ,
  input  logic [c_addr_w-1:0] CTR_ADDR,
  output logic                CPU_GNT,
  output logic                CTR_GNT,
  output logic                BUSY,
  output logic [3:0]          TP,
  output logic [2:0]          EB,
  output logic [3:0]          YB,
  output logic [7:0]          XT,
  output logic [7:0]          XB,
  output logic                REX,
  output logic                REY,
  output logic                SBE,
  output logic                ZID,
  output logic                WEX,
  output logic                WEY,
  output logic                CYDONE
);

  localparam int CNT_W = (TP_CLKS > 1) ? $clog2(TP_CLKS) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TP_CLKS - 1);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_tp, w_tp_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [c_addr_w-1:0] r_addr, w_addr_nxt;

  logic w_last_clk, w_arb, w_cpu_pri, w_ctr_win, w_cpu_win, w_busy_nxt;
  logic [3:0] w_tp_inc;
  logic [3:0] w_yb_nxt;
  logic [7:0] w_xt_nxt, w_xb_nxt;

  assign w_last_clk = (r_cnt == c_cnt_last);
  assign w_tp_inc   = r_tp + 4'd1;

  // Arbitration point: idle, or the final clock of T12 for back-to-back cycles
  assign w_arb = !GOJAM &&
                 ((r_state == ST_IDLE) ||
                  ((r_state == ST_WR) && (r_tp == c_t12) && w_last_clk));

`ifdef ERAS_FAIR_EN
  // Consecutive CTR wins while CPU was waiting
  logic [1:0] r_fair;

  assign w_cpu_pri = CPU_REQ && (r_fair == 2'd2);

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_fair <= 2'd0;
    end else if (w_arb) begin
      if (!CPU_REQ || w_cpu_win)
        r_fair <= 2'd0;
      else if (w_ctr_win)
        r_fair <= r_fair + 2'd1;
    end
  end
`else
  assign w_cpu_pri = 1'b0;
`endif

  assign w_ctr_win = w_arb && CTR_REQ && !w_cpu_pri;
  assign w_cpu_win = w_arb && CPU_REQ && !w_ctr_win;

  always_comb begin
    w_state_nxt = r_state;
    w_tp_nxt    = r_tp;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;

    case (r_state)
      ST_IDLE: begin
        w_tp_nxt  = c_t00;
        w_cnt_nxt = '0;
      end
      ST_RD, ST_WR: begin
        if ((r_state == ST_RD) && GOJAM) begin
          // Abort during read; write-phase aborts are deferred to T12
          w_state_nxt = ST_IDLE;
          w_tp_nxt    = c_t00;
          w_cnt_nxt   = '0;
        end else if (!w_last_clk) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
          if (r_tp == c_t12) begin
            w_state_nxt = ST_IDLE;
            w_tp_nxt    = c_t00;
          end else begin
            w_tp_nxt    = w_tp_inc;
            w_state_nxt = (w_tp_inc > c_rd_last) ? ST_WR : ST_RD;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tp_nxt    = c_t00;
        w_cnt_nxt   = '0;
      end
    endcase

    // A winning request overrides the idle/end-of-cycle transition
    if (w_ctr_win || w_cpu_win) begin
      w_state_nxt = ST_RD;
      w_tp_nxt    = c_t01;
      w_cnt_nxt   = '0;
      w_addr_nxt  = w_ctr_win ? CTR_ADDR : CPU_ADDR;
    end
  end

  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  // Selects are decoded from the next-state address so they register
  // together with the grant and appear in the first clock of T01.
  onehot_dec #(.N(c_yb_sel_w)) u_yb_dec (
    .en  (w_busy_nxt),
    .sel (w_addr_nxt[c_yb_lsb +: c_yb_sel_w]),
    .dec (w_yb_nxt)
  );

  onehot_dec #(.N(c_xt_sel_w)) u_xt_dec (
    .en  (w_busy_nxt),
    .sel (w_addr_nxt[c_xt_lsb +: c_xt_sel_w]),
    .dec (w_xt_nxt)
  );

  onehot_dec #(.N(c_xb_sel_w)) u_xb_dec (
    .en  (w_busy_nxt),
    .sel (w_addr_nxt[c_xb_lsb +: c_xb_sel_w]),
    .dec (w_xb_nxt)
  );

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_tp    <= c_t00;
      r_cnt   <= '0;
      r_addr  <= '0;
      CPU_GNT <= 1'b0;
      CTR_GNT <= 1'b0;
      BUSY    <= 1'b0;
      EB      <= '0;
      YB      <= '0;
      XT      <= '0;
      XB      <= '0;
      REX     <= 1'b0;
      REY     <= 1'b0;
      SBE     <= 1'b0;
      ZID     <= 1'b0;
      WEX     <= 1'b0;
      WEY     <= 1'b0;
      CYDONE  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tp    <= w_tp_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      CPU_GNT <= w_cpu_win;
      CTR_GNT <= w_ctr_win;
      BUSY    <= w_busy_nxt;
      EB      <= w_busy_nxt ? w_addr_nxt[c_eb_lsb +: c_eb_w] : '0;
      YB      <= w_yb_nxt;
      XT      <= w_xt_nxt;
      XB      <= w_xb_nxt;
      // w_tp_nxt is 0 when idle, which lies outside every window
      REX     <= in_window(w_tp_nxt, c_re_first, c_re_last);
      REY     <= in_window(w_tp_nxt, c_re_first, c_re_last);
      SBE     <= in_window(w_tp_nxt, c_sbe_first, c_sbe_last);
      ZID     <= in_window(w_tp_nxt, c_zid_first, c_zid_last);
      WEX     <= in_window(w_tp_nxt, c_we_first, c_we_last);
      WEY     <= in_window(w_tp_nxt, c_we_first, c_we_last);
      CYDONE  <= (w_state_nxt == ST_WR) && (w_tp_nxt == c_t12) &&
                 (w_cnt_nxt == c_cnt_last);
    end
  end

  assign TP = r_tp;

endmodule

`default_nettype wire

// File: tb/tb_erasable_cycle_ctl.sv
// +----------------------------------------------------------------------+
// | tb_erasable_cycle_ctl                                                |
// | Directed self-checking bench for erasable_cycle_ctl, TP_CLKS = 2.    |
// | Honors ERAS_FAIR_EN for the expected arbitration order.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_erasable_cycle_ctl;

  logic        CLOCK = 1'b0;
  logic        rst_  = 1'b0;
  logic        GOJAM = 1'b0;
  logic        CPU_REQ = 1'b0;
  logic [10:0] CPU_ADDR = '0;
  logic        CTR_REQ = 1'b0;
  logic [10:0] CTR_ADDR = '0;
  logic        CPU_GNT, CTR_GNT, BUSY;
  logic [3:0]  TP;
  logic [2:0]  EB;
  logic [3:0]  YB;
  logic [7:0]  XT, XB;
  logic        REX, REY, SBE, ZID, WEX, WEY, CYDONE;

  int total = 0;
  int bad   = 0;

  erasable_cycle_ctl #(.TP_CLKS(2)) dut (
    .CLOCK    (CLOCK),
    .rst_     (rst_),
    .GOJAM    (GOJAM),
    .CPU_REQ  (CPU_REQ),
    .CPU_ADDR (CPU_ADDR),
    .CTR_REQ  (CTR_REQ),
    .CTR_ADDR (CTR_ADDR),
    .CPU_GNT  (CPU_GNT),
    .CTR_GNT  (CTR_GNT),
    .BUSY     (BUSY),
    .TP       (TP),
    .EB       (EB),
    .YB       (YB),
    .XT       (XT),
    .XB       (XB),
    .REX      (REX),
    .REY      (REY),
    .SBE      (SBE),
    .ZID      (ZID),
    .WEX      (WEX),
    .WEY      (WEY),
    .CYDONE   (CYDONE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!BUSY) break;
      tick();
    end
    check("idle_wait", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  found, is_cpu, any_cd;
    bit  exp_cpu [6];

    // ---------------- reset state (before any clock edge)
    #3;
    check("rst_busy", {31'd0, BUSY}, 0);
    check("rst_tp", {28'd0, TP}, 0);
    check("rst_gnt", {30'd0, CPU_GNT, CTR_GNT}, 0);
    check("rst_sel", {EB, YB, XT, XB}, 0);
    tick(); tick();
    rst_ = 1'b1;
    tick();
    check("idle_busy", {31'd0, BUSY}, 0);

    // ---------------- 1: single CPU cycle, addr 0x2A5
    CPU_ADDR = 11'h2A5;
    CPU_REQ  = 1'b1;
    tick();                                   // clock 1
    check("t1_cpu_gnt", {31'd0, CPU_GNT}, 1);
    check("t1_ctr_gnt", {31'd0, CTR_GNT}, 0);
    check("t1_tp", {28'd0, TP}, 1);
    check("t1_busy", {31'd0, BUSY}, 1);
    check("t1_eb", {29'd0, EB}, 2);
    check("t1_yb", {28'd0, YB}, 32'h4);
    check("t1_xt", {24'd0, XT}, 32'h10);
    check("t1_xb", {24'd0, XB}, 32'h20);
    check("t1_rex_c1", {31'd0, REX}, 0);
    CPU_REQ = 1'b0;
    for (int c = 2; c <= 24; c++) begin
      tick();
      check("t1_tp_seq", {28'd0, TP}, (c + 1) / 2);
      check("t1_rex", {31'd0, REX}, (c >= 3 && c <= 8) ? 1 : 0);
      check("t1_rey", {31'd0, REY}, (c >= 3 && c <= 8) ? 1 : 0);
      check("t1_sbe", {31'd0, SBE}, (c >= 7 && c <= 8) ? 1 : 0);
      check("t1_wex", {31'd0, WEX}, (c >= 15 && c <= 20) ? 1 : 0);
      check("t1_zid", {31'd0, ZID}, (c >= 15 && c <= 20) ? 1 : 0);
      check("t1_cydone", {31'd0, CYDONE}, (c == 24) ? 1 : 0);
      check("t1_gnt_low", {31'd0, CPU_GNT}, 0);
    end
    check("t1_xb_hold", {24'd0, XB}, 32'h20);
    tick();                                   // after cycle
    check("t1_end_busy", {31'd0, BUSY}, 0);
    check("t1_end_tp", {28'd0, TP}, 0);
    check("t1_end_sel", {EB, YB, XT, XB}, 0);
    check("t1_end_cyd", {31'd0, CYDONE}, 0);

    // ---------------- 2: simultaneous requests, CTR first, CPU back-to-back
    CPU_ADDR = 11'h001;
    CTR_ADDR = 11'h7FF;
    CPU_REQ  = 1'b1;
    CTR_REQ  = 1'b1;
    tick();
    check("t2_ctr_gnt", {31'd0, CTR_GNT}, 1);
    check("t2_cpu_gnt0", {31'd0, CPU_GNT}, 0);
    check("t2_ctr_sel", {EB, YB, XT, XB}, {3'd7, 4'h8, 8'h80, 8'h80});
    CTR_REQ = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (CPU_GNT) break;
    end
    check("t2_cpu_lat", n, 24);
    check("t2_cpu_tp", {28'd0, TP}, 1);
    check("t2_cpu_sel", {EB, YB, XT, XB}, {3'd0, 4'h1, 8'h01, 8'h02});
    CPU_REQ = 1'b0;
    wait_idle();

    // ---------------- 3: GOJAM during T03 aborts the read
    CPU_ADDR = 11'h123;
    CPU_REQ  = 1'b1;
    tick();
    CPU_REQ = 1'b0;
    for (int k = 0; k < 4; k++) tick();       // clock 5 = T03
    check("t3_tp_pre", {28'd0, TP}, 3);
    check("t3_rex_pre", {31'd0, REX}, 1);
    GOJAM = 1'b1;
    tick();
    GOJAM = 1'b0;
    check("t3_busy", {31'd0, BUSY}, 0);
    check("t3_tp", {28'd0, TP}, 0);
    check("t3_strobes", {26'd0, REX, REY, SBE, ZID, WEX, WEY}, 0);
    check("t3_sel", {EB, YB, XT, XB}, 0);
    any_cd = CYDONE;
    for (int k = 0; k < 26; k++) begin
      tick();
      any_cd |= CYDONE;
    end
    check("t3_no_cydone", {31'd0, any_cd}, 0);

    // ---------------- 4: GOJAM during T08 lets the write-back finish
    CPU_ADDR = 11'h0AA;
    CPU_REQ  = 1'b1;
    tick();
    CPU_REQ = 1'b0;
    for (int k = 0; k < 14; k++) tick();      // clock 15 = T08
    check("t4_tp_pre", {28'd0, TP}, 8);
    GOJAM   = 1'b1;
    CPU_REQ = 1'b1;
    tick();                                   // clock 16
    check("t4_wex", {31'd0, WEX}, 1);
    check("t4_busy", {31'd0, BUSY}, 1);
    for (int k = 0; k < 8; k++) tick();       // clock 24
    check("t4_cydone", {31'd0, CYDONE}, 1);
    check("t4_tp12", {28'd0, TP}, 12);
    tick();
    check("t4_no_gnt", {31'd0, CPU_GNT}, 0);
    check("t4_idle", {31'd0, BUSY}, 0);
    tick(); tick();
    check("t4_no_gnt2", {31'd0, CPU_GNT}, 0);
    GOJAM = 1'b0;
    tick();
    check("t4_gnt_after", {31'd0, CPU_GNT}, 1);
    CPU_REQ = 1'b0;
    wait_idle();

    // ---------------- 5: CTR held continuously with CPU pending
`ifdef ERAS_FAIR_EN
    exp_cpu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_cpu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    CPU_ADDR = 11'h111;
    CTR_ADDR = 11'h222;
    CPU_REQ  = 1'b1;
    CTR_REQ  = 1'b1;
    for (int g = 0; g < 6; g++) begin
      found  = 1'b0;
      is_cpu = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (CPU_GNT || CTR_GNT) begin
          found  = 1'b1;
          is_cpu = CPU_GNT;
          break;
        end
      end
      check("t5_found", {31'd0, found}, 1);
      check("t5_winner", {31'd0, is_cpu}, {31'd0, exp_cpu[g]});
    end
    CPU_REQ = 1'b0;
    CTR_REQ = 1'b0;
    wait_idle();

    // ---------------- 6: asynchronous reset mid-T09
    CPU_ADDR = 11'h2A5;
    CPU_REQ  = 1'b1;
    tick();
    CPU_REQ = 1'b0;
    for (int k = 0; k < 16; k++) tick();      // clock 17 = T09
    check("t6_tp_pre", {28'd0, TP}, 9);
    check("t6_wex_pre", {31'd0, WEX}, 1);
    #2;
    rst_ = 1'b0;
    #1;
    check("t6_busy", {31'd0, BUSY}, 0);
    check("t6_tp", {28'd0, TP}, 0);
    check("t6_strobes", {26'd0, REX, REY, SBE, ZID, WEX, WEY}, 0);
    check("t6_sel", {EB, YB, XT, XB}, 0);
    CPU_ADDR = 11'h055;
    CPU_REQ  = 1'b1;
    tick();
    check("t6_held", {31'd0, BUSY}, 0);
    rst_ = 1'b1;
    tick();
    check("t6_gnt", {31'd0, CPU_GNT}, 1);
    check("t6_tp1", {28'd0, TP}, 1);
    check("t6_sel_new", {EB, YB, XT, XB}, {3'd0, 4'h2, 8'h04, 8'h20});
    CPU_REQ = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/erasable_cycle_ctl.md
# erasable_cycle_ctl

Arbiter and cycle sequencer for the erasable (core) memory. It accepts requests from the instruction sequencer (CPU) and the counter-increment logic (CTR) and grants one per memory cycle. For each granted access it runs a fixed 12-time-pulse read/write-back cycle, driving the address selects (bank, YB, XT, XB) and the read, sense, inhibit and write strobes to the erasable driver and sense logic.

## Interface
- TP_CLKS, 2, number of CLOCK cycles per time pulse; legal range ≥1.
- CLOCK  in  1  system clock; all state changes on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- GOJAM  in  1  synchronous restart/abort request.
- CPU_REQ  in  1  CPU access request; held until CPU_GNT.
- CPU_ADDR  in  11  CPU erasable address; held with CPU_REQ.
- CTR_REQ  in  1  counter-increment access request; held until CTR_GNT.
- CTR_ADDR  in  11  counter address.
- CPU_GNT  out  1  one-clock grant pulse.
- CTR_GNT  out  1  one-clock grant pulse.
- BUSY  out  1  high while a cycle is in progress.
- TP  out  4  current time pulse, 1–12; 0 when idle.
- EB  out  3  bank select, from latched addr[10:8].
- YB  out  4  one-hot, from addr[7:6].
- XT  out  8  one-hot, from addr[5:3].
- XB  out  8  one-hot, from addr[2:0].
- REX, REY  out  1  read-current strobes.
- SBE  out  1  sense-amplifier strobe.
- ZID  out  1  inhibit drive for zero bits of the write-back.
- WEX, WEY  out  1  write-current strobes.
- CYDONE  out  1  one-clock pulse marking the end of the cycle.

## Operation
- States:
  - IDLE.
  - RD: T01–T06.
  - WR: T07–T12.
- Each time pulse lasts TP_CLKS clocks. A full cycle is 12·TP_CLKS clocks.
- Arbitration takes place at a rising edge when the block is in IDLE, or at the last clock of T12 (back-to-back operation). GOJAM must be low for arbitration to occur.
- Priority: CTR wins over CPU.
- Winner's address is latched at the arbitration edge. TP becomes 1, and the grant pulse is high for the first clock of T01.
- Selects (EB/YB/XT/XB): valid from T01 through T12. Outside a cycle, all selects are 0.
- Strobe windows:
  - REX and REY: T02–T04.
  - SBE: T04.
  - ZID: T08–T10.
  - WEX and WEY: T08–T10.
  - All strobes are 0 outside their windows.
- CYDONE: high on the last clock of T12. After that edge, the block either starts the next cycle or returns to IDLE.
- GOJAM in RD: takes effect at the next edge. The block goes to IDLE, all outputs go to 0, and CYDONE does not pulse.
- GOJAM in WR: the write-back completes so that data destroyed by the read is restored. CYDONE pulses, and no new grant is issued while GOJAM is high.
- A request deasserted before it is granted is dropped. No grant is issued for it.
- Reset: all outputs go to 0 and the state goes to IDLE immediately, without waiting for a clock edge. The arbitration history is cleared.

## Timing
- Latency from a request rising in IDLE to the grant: 1 edge. The grant is high during the clock following the sampling edge.
- Address-to-select latency: the selects are valid in the same clock as the grant.
- Back-to-back cycles have no idle clock between the last clock of T12 and the first clock of T01.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- ERAS_FAIR_EN defined: starvation guard is enabled.
  - If CTR has won 2 consecutive arbitrations while CPU_REQ was pending, CPU wins the next one.
  - The counter resets on any CPU grant and when CPU_REQ is low at arbitration.
- ERAS_FAIR_EN undefined: strict CTR priority; CPU can starve.

## Structure
- Package erasable_pkg holds:
  - Address field widths and bit positions.
  - TP constants T01–T12.
  - Strobe window start and end constants.
  - State enum (IDLE/RD/WR).
- Sub-module onehot_dec (parameterised N→2^N one-hot with an enable input), instantiated for YB, XT and XB.

## Test plan
Benches use TP_CLKS=2.
1. CPU_REQ with CPU_ADDR=0x2A5 from IDLE:
   - CPU_GNT pulse 1 clock later.
   - EB=2, YB=4'b0100, XT=8'h10, XB=8'h20.
   - REX high during clocks 3–8 of the cycle, SBE during clocks 7–8, WEX during clocks 15–20.
   - CYDONE on clock 24.
2. CPU_REQ and CTR_REQ rise on the same edge:
   - CTR_GNT first.
   - CPU_GNT in the first clock of T01 of the next cycle, exactly 24 clocks after CTR_GNT.
3. GOJAM pulsed during T03:
   - Next edge: BUSY=0, TP=0, all strobes 0, no CYDONE.
4. GOJAM pulsed during T08:
   - Cycle completes and CYDONE pulses.
   - A CPU_REQ held during GOJAM is not granted until GOJAM is low.
5. CTR_REQ held continuously with CPU_REQ pending:
   - With ERAS_FAIR_EN, grant order is CTR, CTR, CPU, CTR, CTR, CPU.
   - Without it, only CTR grants occur.
6. rst_ asserted mid-T09 between clock edges:
   - All outputs 0 immediately.
   - After release, a pending CPU_REQ is granted 1 edge later.
